nmr_vote_ctrl: RTL and testbench
================================

Name: nmr_vote_ctrl

Overview:
- Parametrised N-modular-redundancy compare/vote controller; successor to the two-channel duplicate-with-compare block.
- Collects one result word from each of NUM_CH processor channels and compares them (all-equal mode) or majority-votes them (vote mode). Drives the voted word to the VGA path and releases each channel through an interrupt/ready handshake.
- Adds per-channel fault flags, a saturating mismatch counter, a collection timeout and lfsr-based fault injection.

Parameters:
- NUM_CH, 3, number of redundant channels (2..8).
- DATA_W, 32, channel data width.
- VGA_W, 12, VGA output width (VGA_W <= DATA_W).
- TIMEOUT, 1024, cycles allowed in COLLECT before forced compare (>= 2).
- CNT_W, 16, mismatch counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous soft clear.
- mode  in  2  0 bypass, 1 all-equal compare, 2 majority vote, 3 treated as 1.
- error_enable  in  1  XOR lfsr_mask into channel 0 at sample time.
- lfsr_mask  in  DATA_W  pseudo-random injection mask.
- data_set  in  NUM_CH  per-channel "data written" flag; level, held until released.
- data  in  NUM_CH*DATA_W  channel words; channel i is at [i*DATA_W +: DATA_W].
- interrupt  out  NUM_CH  per-channel release request.
- ready  out  NUM_CH  one-cycle release acknowledge.
- done  out  1  result valid.
- match  out  1  compare passed / majority found.
- voted_data  out  DATA_W  voted word.
- vga_output  out  VGA_W  display word.
- fault_ch  out  NUM_CH  channel disagreed or was missing.
- mismatch_count  out  CNT_W  saturating failure count.
- timeout  out  1  sticky; last compare was forced.

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE. All outputs are 0, including vga_output, counters and the sticky timeout flag.
- clear (sync, wins over FSM): same effect as reset on the next edge.
- All outputs are registered.
- mode is sampled only in IDLE and latched until the FSM returns to IDLE.
- Bypass (mode 0): FSM stays in IDLE. Every cycle voted_data <= data[ch0] and vga_output <= data[ch0][VGA_W-1:0]. done, match, interrupt and ready stay 0.
- FSM states: IDLE, COLLECT, COMPARE, RELEASE.
- IDLE, non-bypass:
  - all data_set bits high -> COMPARE;
  - some bits high -> COLLECT, timer cleared;
  - no bits high -> stay in IDLE.
- COLLECT: timer increments each cycle.
  - All bits high -> COMPARE.
  - Timer reaches TIMEOUT-1 -> COMPARE with forced=1.
  - All bits low -> IDLE.
- COMPARE (1 cycle):
  - Samples data; a channel counts as present if its data_set bit is high. ch0 is XORed with lfsr_mask when error_enable=1.
  - Registers results, then moves to RELEASE with idx=NUM_CH-1.
  - Results are visible the cycle after COMPARE with done=1. Latency from all data_set high to done high is 2 cycles.
- Compare mode results:
  - match=1 when all present channels are equal and none is missing. Then voted_data=ch0 and fault_ch=0.
  - Otherwise match=0, voted_data all ones, and fault_ch bit set for each missing channel or each channel differing from ch0.
  - With NUM_CH=2 this is identical to the original DWC behaviour.
- Vote mode results:
  - agree[i] = number of present channels equal to channel i.
  - Winner = lowest-index present channel with agree > NUM_CH/2 (integer division, total channel count).
  - Winner exists: match=1, voted_data=winner, fault_ch = channels missing or not equal to the winner.
  - No winner: match=0, voted_data all ones, fault_ch all ones.
- vga_output = voted_data[VGA_W-1:0] (all ones on failure).
- mismatch_count increments (saturating at 2^CNT_W-1) whenever a COMPARE yields any fault_ch bit set.
- timeout is set at COMPARE if forced=1 and held until clear or reset.
- RELEASE (descending idx):
  - interrupt[idx]=1 while waiting.
  - When data_set[idx]==0: interrupt[idx] drops, ready[idx] pulses one cycle, idx decrements.
  - A missing channel (already low) completes in one cycle, still with a ready pulse.
  - After idx 0 completes -> IDLE; done clears on IDLE entry.
  - match, voted_data, fault_ch and vga_output hold until the next COMPARE.
- data_set rising in RELEASE for an already-released channel is ignored until IDLE.
- Only one interrupt bit is high at a time.

Test Plan:
- NUM_CH=3, mode 1, all channels 0x0000_0ABC, data_set all high:
  - done=1 two cycles later, match=1, vga_output=0xABC, fault_ch=0;
  - interrupts run ch2, ch1, ch0, each ready pulsing after its data_set drops.
- Mode 2, ch1=0x5, ch0=ch2=0x7 -> match=1, voted_data=0x7, fault_ch=3'b010, mismatch_count=1.
- Mode 2, channels 0x1/0x2/0x3 -> match=0, vga_output=0xFFF, fault_ch=3'b111.
- Mode 2, error_enable=1, lfsr_mask=0x1, all channels 0x10 -> ch0 seen as 0x11; voted_data=0x10, fault_ch=3'b001.
- TIMEOUT=8, only ch0 and ch1 set, both 0x4, mode 2:
  - forced COMPARE after 8 cycles; timeout=1, match=1, fault_ch=3'b100;
  - ch2 release completes immediately.
- Mode 0 with data[ch0] changing every cycle: vga_output follows one cycle later, done stays 0. Then rst low mid-RELEASE: all outputs 0 immediately.

Source files
------------

// File: rtl/nmr_vote_ctrl.sv
// rtl/nmr_vote_ctrl.sv - N-modular-redundancy compare/vote controller with release handshake
module nmr_vote_ctrl #(
   parameter int NUM_CH  = 3,
   parameter int DATA_W  = 32,
   parameter int VGA_W   = 12,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic [1:0]               mode,
   input  logic                     error_enable,
   input  logic [DATA_W-1:0]        lfsr_mask,
   input  logic [NUM_CH-1:0]        data_set,
   input  logic [NUM_CH*DATA_W-1:0] data,
   output logic [NUM_CH-1:0]        interrupt,
   output logic [NUM_CH-1:0]        ready,
   output logic                     done,
   output logic                     match,
   output logic [DATA_W-1:0]        voted_data,
   output logic [VGA_W-1:0]         vga_output,
   output logic [NUM_CH-1:0]        fault_ch,
   output logic [CNT_W-1:0]         mismatch_count,
   output logic                     timeout
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0]     T_LAST  = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0]     IDX_TOP = IW'(NUM_CH - 1);
   localparam logic [3:0]        HALF    = 4'(NUM_CH / 2);
   localparam logic [NUM_CH-1:0] ONE     = NUM_CH'(1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMPARE, S_RELEASE} state_t;

   state_t              state, state_nx;
   logic [1:0]          mode_q;
   logic [TW-1:0]       timer;
   logic                forced;
   logic [IW-1:0]       idx;
   logic                all_set, any_set, vote_mode;
   logic [DATA_W-1:0]   ch [NUM_CH];
   logic [3:0]          agree [NUM_CH];
   logic                win_found;
   logic [DATA_W-1:0]   win_val;
   logic                res_match;
   logic [DATA_W-1:0]   res_voted;
   logic [NUM_CH-1:0]   res_fault;

   assign all_set   = &data_set;
   assign any_set   = |data_set;
   assign vote_mode = (mode_q == 2'd2);

   // Unpack channel words; fault injection only ever touches channel 0
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch[i] = data[i*DATA_W +: DATA_W];
      end
      if (error_enable) begin
         ch[0] = data[DATA_W-1:0] ^ lfsr_mask;
      end
   end

   // Compare / majority evaluation of the currently presented channels
   always_comb begin
      res_match = 1'b0;
      res_voted = '1;
      res_fault = '1;
      win_found = 1'b0;
      win_val   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         agree[i] = 4'd0;
         for (int j = 0; j < NUM_CH; j++) begin
            if (data_set[j] && (ch[j] == ch[i])) begin
               agree[i] = agree[i] + 4'd1;
            end
         end
      end
      if (vote_mode) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!win_found && data_set[i] && (agree[i] > HALF)) begin
               win_found = 1'b1;
               win_val   = ch[i];
            end
         end
         if (win_found) begin
            res_match = 1'b1;
            res_voted = win_val;
            for (int i = 0; i < NUM_CH; i++) begin
               res_fault[i] = !data_set[i] || (ch[i] != win_val);
            end
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            res_fault[i] = !data_set[i] || (ch[i] != ch[0]);
         end
         if (res_fault == '0) begin
            res_match = 1'b1;
            res_voted = ch[0];
         end
      end
   end

   // State register; soft clear behaves like reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else if (clear) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decision
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (mode != 2'd0) begin
               if (all_set) begin
                  state_nx = S_COMPARE;
               end else if (any_set) begin
                  state_nx = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            if (all_set || (timer == T_LAST)) begin
               state_nx = S_COMPARE;
            end else if (!any_set) begin
               state_nx = S_IDLE;
            end
         end
         S_COMPARE: begin
            state_nx = S_RELEASE;
         end
         S_RELEASE: begin
            if (!data_set[idx] && (idx == '0)) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Registered datapath: timer, results, counters and release handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q         <= 2'd0;
         timer          <= '0;
         forced         <= 1'b0;
         idx            <= '0;
         interrupt      <= '0;
         ready          <= '0;
         done           <= 1'b0;
         match          <= 1'b0;
         voted_data     <= '0;
         vga_output     <= '0;
         fault_ch       <= '0;
         mismatch_count <= '0;
         timeout        <= 1'b0;
      end else if (clear) begin
         mode_q         <= 2'd0;
         timer          <= '0;
         forced         <= 1'b0;
         idx            <= '0;
         interrupt      <= '0;
         ready          <= '0;
         done           <= 1'b0;
         match          <= 1'b0;
         voted_data     <= '0;
         vga_output     <= '0;
         fault_ch       <= '0;
         mismatch_count <= '0;
         timeout        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               timer     <= '0;
               forced    <= 1'b0;
               mode_q    <= mode;
               ready     <= '0;
               interrupt <= '0;
               if (mode == 2'd0) begin
                  voted_data <= data[DATA_W-1:0];
                  vga_output <= data[VGA_W-1:0];
               end
            end
            S_COLLECT: begin
               timer  <= timer + 1'b1;
               forced <= !all_set && (timer == T_LAST);
            end
            S_COMPARE: begin
               done       <= 1'b1;
               match      <= res_match;
               voted_data <= res_voted;
               vga_output <= res_voted[VGA_W-1:0];
               fault_ch   <= res_fault;
               if ((res_fault != '0) && (mismatch_count != '1)) begin
                  mismatch_count <= mismatch_count + 1'b1;
               end
               if (forced) begin
                  timeout <= 1'b1;
               end
               idx       <= IDX_TOP;
               interrupt <= ONE << IDX_TOP;
            end
            S_RELEASE: begin
               ready <= '0;
               if (!data_set[idx]) begin
                  ready <= ONE << idx;
                  if (idx == '0) begin
                     interrupt <= '0;
                     done      <= 1'b0;
                  end else begin
                     interrupt <= ONE << (idx - 1'b1);
                     idx       <= idx - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nmr_vote_ctrl.sv
// tb/tb_nmr_vote_ctrl.sv - scoreboard bench for nmr_vote_ctrl
`timescale 1ns/1ps
module tb_nmr_vote_ctrl;

   localparam int NUM_CH = 3;
   localparam int DATA_W = 32;
   localparam int VGA_W  = 12;
   localparam int TOUT   = 8;
   localparam int CNT_W  = 16;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     clear = 1'b0;
   logic [1:0]               mode = 2'd0;
   logic                     error_enable = 1'b0;
   logic [DATA_W-1:0]        lfsr_mask = '0;
   logic [NUM_CH-1:0]        data_set = '0;
   logic [NUM_CH*DATA_W-1:0] data = '0;
   logic [NUM_CH-1:0]        interrupt;
   logic [NUM_CH-1:0]        ready;
   logic                     done;
   logic                     match;
   logic [DATA_W-1:0]        voted_data;
   logic [VGA_W-1:0]         vga_output;
   logic [NUM_CH-1:0]        fault_ch;
   logic [CNT_W-1:0]         mismatch_count;
   logic                     timeout;

   typedef struct packed {
      logic              m;
      logic [DATA_W-1:0] v;
      logic [NUM_CH-1:0] f;
      logic [CNT_W-1:0]  c;
      logic              t;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   nmr_vote_ctrl #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .VGA_W(VGA_W), .TIMEOUT(TOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .clear(clear), .mode(mode),
      .error_enable(error_enable), .lfsr_mask(lfsr_mask),
      .data_set(data_set), .data(data),
      .interrupt(interrupt), .ready(ready), .done(done), .match(match),
      .voted_data(voted_data), .vga_output(vga_output), .fault_ch(fault_ch),
      .mismatch_count(mismatch_count), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_txn(input logic [1:0] m, input logic [2:0] ds,
                            input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                            input logic ee, input logic [31:0] msk, input exp_t e);
      sb_q.push_back(e);
      mode         = m;
      error_enable = ee;
      lfsr_mask    = msk;
      data         = {c2, c1, c0};
      data_set     = ds;
   endtask

   task automatic wait_result(input int lat);
      int   cyc;
      exp_t e;
      cyc = 0;
      while (!done && cyc < 50) begin
         step();
         cyc++;
      end
      check("done_seen", done, 1'b1);
      check("latency", cyc, lat);
      e = sb_q.pop_front();
      check("match", match, e.m);
      check("voted", voted_data, e.v);
      check("vga", vga_output, e.v[VGA_W-1:0]);
      check("fault", fault_ch, e.f);
      check("count", mismatch_count, e.c);
      check("timeout", timeout, e.t);
   endtask

   task automatic release_all(input int hold_ch);
      logic [NUM_CH-1:0] oh;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         oh = NUM_CH'(1) << c;
         check("int_active", interrupt, oh);
         if (c == hold_ch) begin
            step();
            check("hold_ready", ready, 3'b000);
            check("hold_int", interrupt, oh);
         end
         data_set[c] = 1'b0;
         step();
         check("ready_pulse", ready, oh);
      end
      check("done_clr", done, 1'b0);
      check("int_clr", interrupt, 3'b000);
      step();
      check("ready_clr", ready, 3'b000);
      error_enable = 1'b0;
   endtask

   initial begin
      logic [31:0] prev;
      logic [31:0] w;
      @(negedge clk);
      check("rst_done", done, 1'b0);
      check("rst_voted", voted_data, 32'h0);
      check("rst_vga", vga_output, 12'h0);
      check("rst_count", mismatch_count, 16'h0);
      check("rst_int", interrupt, 3'b000);
      rst = 1'b1;
      step();

      start_txn(2'd1, 3'b111, 32'hABC, 32'hABC, 32'hABC, 1'b0, 32'h0,
                '{m:1'b1, v:32'hABC, f:3'b000, c:16'd0, t:1'b0});
      wait_result(2);
      release_all(1);

      start_txn(2'd2, 3'b111, 32'h7, 32'h5, 32'h7, 1'b0, 32'h0,
                '{m:1'b1, v:32'h7, f:3'b010, c:16'd1, t:1'b0});
      wait_result(2);
      release_all(-1);

      start_txn(2'd2, 3'b111, 32'h1, 32'h2, 32'h3, 1'b0, 32'h0,
                '{m:1'b0, v:32'hFFFF_FFFF, f:3'b111, c:16'd2, t:1'b0});
      wait_result(2);
      release_all(-1);

      start_txn(2'd2, 3'b111, 32'h10, 32'h10, 32'h10, 1'b1, 32'h1,
                '{m:1'b1, v:32'h10, f:3'b001, c:16'd3, t:1'b0});
      wait_result(2);
      release_all(-1);

      start_txn(2'd2, 3'b011, 32'h4, 32'h4, 32'h0, 1'b0, 32'h0,
                '{m:1'b1, v:32'h4, f:3'b100, c:16'd4, t:1'b1});
      wait_result(TOUT + 2);
      release_all(-1);
      check("timeout_sticky", timeout, 1'b1);

      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_timeout", timeout, 1'b0);
      check("clr_count", mismatch_count, 16'h0);
      check("clr_vga", vga_output, 12'h0);

      mode = 2'd0;
      data_set = '0;
      prev = 32'h0;
      for (int k = 0; k < 6; k++) begin
         w = $urandom;
         data = {32'h0, 32'h0, w};
         step();
         check("byp_voted", voted_data, w);
         check("byp_vga", vga_output, w[VGA_W-1:0]);
         check("byp_done", done, 1'b0);
         check("byp_int", interrupt, 3'b000);
         prev = w;
      end
      step();
      check("byp_hold", voted_data, prev);

      start_txn(2'd1, 3'b111, 32'h22, 32'h23, 32'h22, 1'b0, 32'h0,
                '{m:1'b0, v:32'hFFFF_FFFF, f:3'b010, c:16'd1, t:1'b0});
      wait_result(2);
      check("mid_int", interrupt, 3'b100);
      rst = 1'b0;
      #1;
      check("arst_done", done, 1'b0);
      check("arst_int", interrupt, 3'b000);
      check("arst_voted", voted_data, 32'h0);
      check("arst_vga", vga_output, 12'h0);
      check("arst_fault", fault_ch, 3'b000);
      check("arst_count", mismatch_count, 16'h0);
      check("arst_match", match, 1'b0);
      data_set = '0;
      step();
      rst = 1'b1;
      step();
      check("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
